// File: rtl/block_reassembler_if.sv
// block_reassembler_if: pixel-in stream and frame-buffer write port of the reassembler
interface block_reassembler_if #(
    parameter int Data_Depth = 8,
    parameter int Addr_Width = 19
);
    logic [Data_Depth-1:0] Pixel_in;
    logic                  new_pixel;
    logic [Addr_Width-1:0] Mem_Addr;
    logic [Data_Depth-1:0] Mem_Data;
    logic                  Mem_WE;
    logic                  Block_Done;
    modport master (output Pixel_in, new_pixel, input Mem_Addr, Mem_Data, Mem_WE, Block_Done);
    modport slave  (input Pixel_in, new_pixel, output Mem_Addr, Mem_Data, Mem_WE, Block_Done);
endinterface

// File: rtl/block_reassembler.sv
// block_reassembler: turns a block-sequential pixel stream into raster-ordered frame-buffer writes
module block_reassembler #(
    parameter int Data_Depth    = 8,
    parameter int Addr_Width    = 19,
    parameter int Max_Img_Width = 720
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  cfg_load,
    input  logic [Data_Depth-1:0] M,
    input  logic [9:0]            Img_W,
    block_reassembler_if.slave    px,
    output logic                  Frame_Done,
    output logic                  Err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                state_q, state_d;
    logic [Data_Depth-1:0] m_q, m_d, col_q, col_d, row_q, row_d, data_q, data_d;
    logic [Addr_Width-1:0] w_q, w_d, stride_q, stride_d, bx_q, bx_d, by_q, by_d;
    logic [Addr_Width-1:0] line_q, line_d, rowb_q, rowb_d, addr_q, addr_d, m_ext;
    logic                  we_q, we_d, bd_q, bd_d, err_q, err_d;
    logic                  cfg_ok, last_col, last_row;
    assign cfg_ok = (M != '0) && (Img_W != '0) && (32'(Img_W) <= Max_Img_Width)
                    && (32'(M) <= 32'(Img_W)) && (32'(Img_W) % 32'(M) == 32'd0);
    assign m_ext      = Addr_Width'(m_q);
    assign last_col   = col_q == m_q - 1'b1;
    assign last_row   = row_q == m_q - 1'b1;
    assign Frame_Done = state_q == DONE;
    assign Err        = err_q;
    assign px.Mem_Addr   = addr_q;
    assign px.Mem_Data   = data_q;
    assign px.Mem_WE     = we_q;
    assign px.Block_Done = bd_q;
    // next state: configuration, pixel acceptance and block/line/row address walking
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        w_d      = w_q;
        stride_d = stride_q;
        col_d    = col_q;
        row_d    = row_q;
        bx_d     = bx_q;
        by_d     = by_q;
        line_d   = line_q;
        rowb_d   = rowb_q;
        addr_d   = addr_q;
        data_d   = data_q;
        err_d    = err_q;
        we_d     = 1'b0;
        bd_d     = 1'b0;
        if (en) begin
            if (cfg_load) begin
                if (cfg_ok) begin
                    m_d      = M;
                    w_d      = Addr_Width'(Img_W);
                    stride_d = Addr_Width'(M) * Addr_Width'(Img_W);
                    col_d    = '0;
                    row_d    = '0;
                    bx_d     = '0;
                    by_d     = '0;
                    line_d   = '0;
                    rowb_d   = '0;
                    err_d    = 1'b0;
                    state_d  = RUN;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end else if (px.new_pixel) begin
                if (state_q != RUN) begin
                    err_d = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    data_d = px.Pixel_in;
                    addr_d = line_q + Addr_Width'(col_q);
                    if (!last_col) begin
                        col_d = col_q + 1'b1;
                    end else if (!last_row) begin
                        col_d  = '0;
                        row_d  = row_q + 1'b1;
                        line_d = line_q + w_q;
                    end else begin
                        bd_d  = 1'b1;
                        col_d = '0;
                        row_d = '0;
                        if (bx_q + m_ext < w_q) begin
                            bx_d   = bx_q + m_ext;
                            line_d = rowb_q + bx_q + m_ext;
                        end else if (by_q + m_ext < w_q) begin
                            bx_d   = '0;
                            by_d   = by_q + m_ext;
                            rowb_d = rowb_q + stride_q;
                            line_d = rowb_q + stride_q;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
        end
    end
    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            m_q      <= '0;
            w_q      <= '0;
            stride_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            line_q   <= '0;
            rowb_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            bd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            w_q      <= w_d;
            stride_q <= stride_d;
            col_q    <= col_d;
            row_q    <= row_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            line_q   <= line_d;
            rowb_q   <= rowb_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            err_q    <= err_d;
            we_q     <= we_d;
            bd_q     <= bd_d;
        end
    end
endmodule

// File: tb/tb_block_reassembler.sv
// tb_block_reassembler: scoreboard bench comparing frame-buffer writes against a raster-address model
module tb_block_reassembler;
    typedef struct packed {
        logic [18:0] a;
        logic [7:0]  d;
        logic        bd;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       cfg_load = 1'b0;
    logic [7:0] M = '0;
    logic [9:0] Img_W = '0;
    logic       Frame_Done, Err;
    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         nwr = 0;
    int         nbd = 0;
    block_reassembler_if #(.Data_Depth(8), .Addr_Width(19)) px();
    block_reassembler dut (
        .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load), .M(M), .Img_W(Img_W),
        .px(px), .Frame_Done(Frame_Done), .Err(Err)
    );
    always #5 clk = ~clk;
    // scoreboard: every observed write must match the oldest expected write
    always @(negedge clk) begin
        if (px.Mem_WE === 1'b1) begin
            exp_t e;
            checks++;
            nwr++;
            if (px.Block_Done === 1'b1) nbd++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%0d bd=%0b", px.Mem_Addr, px.Mem_Data, px.Block_Done);
            end else begin
                e = exp_q.pop_front();
                if ({px.Mem_Addr, px.Mem_Data, px.Block_Done} !== e) begin
                    failures++;
                    $display("FAIL write got addr=%0d data=%0d bd=%0b want addr=%0d data=%0d bd=%0b",
                             px.Mem_Addr, px.Mem_Data, px.Block_Done, e.a, e.d, e.bd);
                end
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    function automatic logic [18:0] ref_addr(input int k, input int m, input int w);
        int bpr = w / m;
        int b = k / (m * m);
        int r = (k % (m * m)) / m;
        int c = k % m;
        return 19'(((b / bpr) * m + r) * w + (b % bpr) * m + c);
    endfunction
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic do_rst();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask
    task automatic cfg(input int m, input int w);
        M = 8'(m);
        Img_W = 10'(w);
        cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
    endtask
    task automatic send(input int k, input int m, input int w, input int v);
        exp_q.push_back({ref_addr(k, m, w), 8'(v), (k % (m * m)) == m * m - 1});
        px.new_pixel = 1'b1;
        px.Pixel_in = 8'(v);
        cyc();
        px.new_pixel = 1'b0;
    endtask
    task automatic drain_check(input string name);
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pending got=%0d want=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({px.Mem_WE, px.Block_Done, Frame_Done, Err} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000", {px.Mem_WE, px.Block_Done, Frame_Done, Err});
        end
        checks++;
        if (px.Mem_Addr !== '0 || px.Mem_Data !== '0) begin
            failures++;
            $display("FAIL reset_bus got addr=%0d data=%0d want 0 0", px.Mem_Addr, px.Mem_Data);
        end
        rst = 1'b0;
        cyc();
    endtask
    task automatic run_frame_2x4();
        int b0 = nbd;
        cfg(2, 4);
        checks++;
        if (Err !== 1'b0 || Frame_Done !== 1'b0) begin
            failures++;
            $display("FAIL cfg24_status got err=%b fd=%b want 0 0", Err, Frame_Done);
        end
        for (int k = 0; k < 16; k++) begin
            if (k == 15) begin
                checks++;
                if (Frame_Done !== 1'b0) begin
                    failures++;
                    $display("FAIL frame_done_early got=%b want=0", Frame_Done);
                end
            end
            send(k, 2, 4, k);
        end
        cyc();
        checks++;
        if (Frame_Done !== 1'b1) begin
            failures++;
            $display("FAIL frame_done got=%b want=1", Frame_Done);
        end
        checks++;
        if (nbd - b0 != 4) begin
            failures++;
            $display("FAIL block_done_count got=%0d want=4", nbd - b0);
        end
        drain_check("frame24");
    endtask
    task automatic test_frame_2x4();
        run_frame_2x4();
    endtask
    task automatic test_en_gaps();
        int b0 = nbd;
        int w0;
        cfg(3, 3);
        for (int k = 0; k < 9; k++) begin
            if (k == 4) begin
                w0 = nwr;
                en = 1'b0;
                px.new_pixel = 1'b1;
                px.Pixel_in = 8'hEE;
                for (int i = 0; i < 3; i++) begin
                    cyc();
                    checks++;
                    if (px.Mem_WE !== 1'b0) begin
                        failures++;
                        $display("FAIL en_low_we got=%b want=0", px.Mem_WE);
                    end
                end
                checks++;
                if (nwr != w0) begin
                    failures++;
                    $display("FAIL en_low_writes got=%0d want=%0d", nwr, w0);
                end
                en = 1'b1;
            end
            send(k, 3, 3, 8'h40 + k);
            repeat ($urandom_range(1, 3)) cyc();
        end
        checks++;
        if (nbd - b0 != 1 || Frame_Done !== 1'b1) begin
            failures++;
            $display("FAIL en_gaps_done got bd=%0d fd=%b want 1 1", nbd - b0, Frame_Done);
        end
        drain_check("en_gaps");
    endtask
    task automatic test_bad_cfg();
        int bm[3] = '{2, 0, 2};
        int bw[3] = '{5, 4, 721};
        for (int i = 0; i < 3; i++) begin
            do_rst();
            cfg(bm[i], bw[i]);
            checks++;
            if (Err !== 1'b1 || Frame_Done !== 1'b0) begin
                failures++;
                $display("FAIL bad_cfg%0d got err=%b fd=%b want 1 0", i, Err, Frame_Done);
            end
            px.new_pixel = 1'b1;
            cyc();
            px.new_pixel = 1'b0;
            cyc();
        end
        drain_check("bad_cfg");
    endtask
    task automatic test_overrun();
        run_frame_2x4();
        checks++;
        if (Err !== 1'b0) begin
            failures++;
            $display("FAIL pre_overrun_err got=%b want=0", Err);
        end
        px.new_pixel = 1'b1;
        px.Pixel_in = 8'h77;
        cyc();
        px.new_pixel = 1'b0;
        checks++;
        if (Err !== 1'b1 || Frame_Done !== 1'b1 || px.Mem_WE !== 1'b0) begin
            failures++;
            $display("FAIL overrun got err=%b fd=%b we=%b want 1 1 0", Err, Frame_Done, px.Mem_WE);
        end
        drain_check("overrun");
    endtask
    task automatic test_rst_mid();
        cfg(2, 4);
        for (int k = 0; k < 6; k++) send(k, 2, 4, k + 100);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if ({px.Mem_WE, px.Block_Done, Frame_Done, Err} !== 4'b0 || px.Mem_Addr !== '0 || px.Mem_Data !== '0) begin
            failures++;
            $display("FAIL rst_mid got we=%b bd=%b fd=%b err=%b addr=%0d data=%0d want all 0",
                     px.Mem_WE, px.Block_Done, Frame_Done, Err, px.Mem_Addr, px.Mem_Data);
        end
        px.new_pixel = 1'b1;
        cyc();
        px.new_pixel = 1'b0;
        checks++;
        if (Err !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_unconfigured got err=%b want=1", Err);
        end
        cfg(2, 4);
        send(0, 2, 4, 8'h5A);
        drain_check("rst_mid");
    endtask
    task automatic test_back_to_back_reconfig();
        int b0;
        cfg(2, 4);
        for (int k = 0; k < 3; k++) send(k, 2, 4, k + 10);
        M = 8'd4;
        Img_W = 10'd8;
        cfg_load = 1'b1;
        px.new_pixel = 1'b1;
        px.Pixel_in = 8'hCC;
        cyc();
        cfg_load = 1'b0;
        px.new_pixel = 1'b0;
        checks++;
        if (Err !== 1'b0) begin
            failures++;
            $display("FAIL reconfig_err got=%b want=0", Err);
        end
        b0 = nbd;
        for (int k = 0; k < 16; k++) send(k, 4, 8, k + 200);
        cyc();
        checks++;
        if (nbd - b0 != 1 || Frame_Done !== 1'b0) begin
            failures++;
            $display("FAIL reconfig_block got bd=%0d fd=%b want 1 0", nbd - b0, Frame_Done);
        end
        drain_check("reconfig");
    endtask
    initial begin
        px.new_pixel = 1'b0;
        px.Pixel_in = '0;
        test_reset();
        test_frame_2x4();
        test_en_gaps();
        test_bad_cfg();
        test_overrun();
        test_rst_mid();
        test_back_to_back_reconfig();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
